// File: rtl/udp_pkg.sv
// Shared encodings and constants for the udp TX packet generator.
package udp_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_END
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GAP_W  = 14;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam int              PRBS_W     = 16;
  localparam logic [PRBS_W-1:0] PRBS_POLY  = 16'hB400;
  localparam logic [PRBS_W-1:0] PRBS_RESET = 16'h0001;

  function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] s);
    prbs_step = {1'b0, s[PRBS_W-1:1]} ^ (s[0] ? PRBS_POLY : '0);
  endfunction

endpackage

// File: rtl/udp_tx_pkt_gen_if.sv
// udp TX user-side handshake: generator is master, udp core is slave.
interface udp_tx_pkt_gen_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) ();

  logic              tx_start_en;
  logic [LEN_W-1:0]  tx_byte_num;
  logic [DATA_W-1:0] tx_data;
  logic              tx_req;
  logic              tx_done;

  modport master (
    output tx_start_en,
    output tx_byte_num,
    output tx_data,
    input  tx_req,
    input  tx_done
  );

  modport slave (
    input  tx_start_en,
    input  tx_byte_num,
    input  tx_data,
    output tx_req,
    output tx_done
  );

endinterface

// File: rtl/udp_pattern_src.sv
// Payload word source: seed load, per-word advance and INCR/CONST/PRBS selection.
module udp_pattern_src
  import udp_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] STEP   = 'h11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              advance,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [PRBS_W-1:0] lfsr_q, lfsr_d;
  logic [PRBS_W-1:0] lfsr_adv;
  logic [PRBS_W-1:0] seed_ext;

  always_comb begin
    data_d   = data_q;
    lfsr_d   = lfsr_q;
    seed_ext = PRBS_W'(seed);
    lfsr_adv = prbs_step(lfsr_q);
    if (load) begin
      data_d = seed;
      // An all-zero LFSR would lock up, so a zero seed starts it from 1.
      lfsr_d = (seed_ext == '0) ? PRBS_RESET : seed_ext;
    end else if (clear) begin
      data_d = '0;
    end else if (advance) begin
      case (mode)
        MODE_INCR: data_d = data_q + STEP;
        MODE_PRBS: begin
          lfsr_d = lfsr_adv;
          data_d = lfsr_adv[DATA_W-1:0];
        end
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      lfsr_q <= PRBS_RESET;
    end else begin
      data_q <= data_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/udp_tx_pkt_gen.sv
// Packet generator for the udp TX interface: N packets of programmable length,
// pattern and inter-packet gap, with a completion pulse.
module udp_tx_pkt_gen
  import udp_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                LEN_W  = DEF_LEN_W,
  parameter int                CNT_W  = DEF_CNT_W,
  parameter int                GAP_W  = DEF_GAP_W,
  parameter logic [DATA_W-1:0] STEP   = 'h11
) (
  input  logic               gmii_tx_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  seed,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic [CNT_W-1:0]   pkt_cnt,
  input  logic [GAP_W-1:0]   gap_cyc,
  udp_tx_pkt_gen_if.master   tx_if,
  output logic               busy,
  output logic [CNT_W-1:0]   pkts_sent,
  output logic               run_done
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  pkts_q, pkts_d;
  logic              stop_pend_q, stop_pend_d;

  logic              stop_hit;
  logic [CNT_W-1:0]  pkts_inc;
  logic              pat_load;
  logic              pat_clear;
  logic              pat_adv;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    pkts_d      = pkts_q;
    stop_pend_d = stop_pend_q;
    pat_load    = 1'b0;
    pat_clear   = 1'b0;
    pat_adv     = 1'b0;
    stop_hit    = stop_pend_q | stop;
    pkts_inc    = (pkts_q == '1) ? pkts_q : pkts_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode_e'(mode);
          seed_d      = seed;
          len_d       = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
          cnt_d       = pkt_cnt;
          gap_d       = gap_cyc;
          pkts_d      = '0;
          stop_pend_d = 1'b0;
          pat_load    = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (stop) stop_pend_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop) stop_pend_d = 1'b1;
        pat_adv = tx_if.tx_req;
        // A packet in flight always completes; stop only takes effect here.
        if (tx_if.tx_done) begin
          pkts_d = pkts_inc;
          if (((cnt_q != '0) && (pkts_inc == cnt_q)) || stop_hit) begin
            pat_clear = 1'b1;
            state_d   = ST_END;
          end else if (gap_q == '0) begin
            pat_load = 1'b1;
            state_d  = ST_START;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_hit) begin
          pat_clear = 1'b1;
          state_d   = ST_END;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          pat_load = 1'b1;
          state_d  = ST_START;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_END: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_INCR;
      seed_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      pkts_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      pkts_q      <= pkts_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // seed_d already selects the live input when the run is being launched.
  udp_pattern_src #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_pattern (
    .clk     (gmii_tx_clk),
    .rst_n   (rst_n),
    .load    (pat_load),
    .clear   (pat_clear),
    .advance (pat_adv),
    .mode    (mode_q),
    .seed    (seed_d),
    .data    (tx_if.tx_data)
  );

  assign tx_if.tx_start_en = (state_q == ST_START);
  assign tx_if.tx_byte_num = len_q;
  assign busy              = (state_q != ST_IDLE) && (state_q != ST_END);
  assign run_done          = (state_q == ST_END);
  assign pkts_sent         = pkts_q;

endmodule

// File: tb/tb_udp_tx_pkt_gen.sv
// Bench for udp_tx_pkt_gen: behavioural udp consumer plus a payload reference model.
module tb_udp_tx_pkt_gen;

  localparam int STEP_I = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [15:0] pkt_len;
  logic [15:0] pkt_cnt;
  logic [13:0] gap_cyc;
  logic        busy;
  logic [15:0] pkts_sent;
  logic        run_done;

  udp_tx_pkt_gen_if #(.DATA_W(8), .LEN_W(16)) tif ();

  udp_tx_pkt_gen #(
    .DATA_W (8),
    .LEN_W  (16),
    .CNT_W  (16),
    .GAP_W  (14),
    .STEP   (8'h11)
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .seed        (seed),
    .pkt_len     (pkt_len),
    .pkt_cnt     (pkt_cnt),
    .gap_cyc     (gap_cyc),
    .tx_if       (tif),
    .busy        (busy),
    .pkts_sent   (pkts_sent),
    .run_done    (run_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: polynomial taps derived from the exponent list.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] mask;
    int ex [4];
    ex   = '{16, 14, 13, 11};
    mask = '0;
    for (int j = 0; j < 4; j++) mask[ex[j]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic logic [7:0] exp_word(input int m, input int sd, input int i);
    logic [15:0] l;
    logic [7:0]  w;
    if (m == 0) return 8'((sd + i * STEP_I) % 256);
    if (m != 2) return 8'(sd);
    l = ((sd % 256) == 0) ? 16'h0001 : 16'(sd % 256);
    w = 8'(sd);
    for (int k = 1; k <= i; k++) begin
      l = lfsr_next(l);
      w = l[7:0];
    end
    return w;
  endfunction

  // Behavioural udp consumer and monitor.
  logic [7:0] rx_q [$];
  int len_obs [$];
  int start_cyc [$];
  int done_cyc [$];
  int rd_cnt;
  int rd_busy_bad;
  int udp_st;
  int udp_rem;
  int udp_wait;

  initial begin
    tif.tx_req  = 1'b0;
    tif.tx_done = 1'b0;
    udp_st = 0; udp_rem = 0; udp_wait = 0; rd_cnt = 0; rd_busy_bad = 0;
    forever begin
      @(negedge clk);
      tif.tx_req  = 1'b0;
      tif.tx_done = 1'b0;
      if (!rst_n) begin
        udp_st = 0;
      end else begin
        if (run_done) begin
          rd_cnt++;
          if (busy) rd_busy_bad++;
        end
        case (udp_st)
          0: if (tif.tx_start_en) begin
            start_cyc.push_back(cyc);
            len_obs.push_back(int'(tif.tx_byte_num));
            udp_rem  = int'(tif.tx_byte_num);
            udp_wait = $urandom_range(0, 2);
            udp_st   = 1;
          end
          1: begin
            if (udp_rem <= 0) begin
              udp_st = 2;
            end else if (udp_wait > 0) begin
              udp_wait--;
            end else if ($urandom_range(0, 3) != 0) begin
              tif.tx_req = 1'b1;
              rx_q.push_back(tif.tx_data);
              udp_rem--;
              if (udp_rem == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                  tif.tx_done = 1'b1;
                  done_cyc.push_back(cyc);
                  udp_st = 0;
                end else begin
                  udp_st = 2;
                end
              end
            end
          end
          default: begin
            tif.tx_done = 1'b1;
            done_cyc.push_back(cyc);
            udp_st = 0;
          end
        endcase
      end
    end
  end

  // stop_at: 0 none, -1 together with start, k>0 a few cycles into packet k.
  task automatic do_run(input string tag, input int m, input int sd, input int ln,
                        input int cn, input int gp, input int stop_at, input bit bstart,
                        input int exp_pkts, input int exp_last);
    int eff_len, t, since, ofs, nbad, fb;
    bit stopped, bstarted;
    logic [7:0] w, lb;
    rx_q.delete(); len_obs.delete(); start_cyc.delete(); done_cyc.delete();
    rd_cnt = 0; rd_busy_bad = 0;
    eff_len = (ln == 0) ? 1 : ln;
    @(negedge clk);
    mode = 2'(m); seed = 8'(sd); pkt_len = 16'(ln); pkt_cnt = 16'(cn); gap_cyc = 14'(gp);
    start = 1'b1;
    stop  = (stop_at < 0);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    // Scramble cfg inputs: only the latched copy may matter now.
    mode = 2'($urandom); seed = 8'($urandom); pkt_len = 16'($urandom_range(1, 50));
    pkt_cnt = 16'($urandom_range(1, 9)); gap_cyc = 14'($urandom_range(0, 9));
    t = 0; since = 0; stopped = 0; bstarted = 0;
    while (rd_cnt == 0 && t < 2500) begin
      @(negedge clk);
      t++;
      start = 1'b0; stop = 1'b0;
      if (stop_at > 0 && start_cyc.size() >= stop_at && !stopped) begin
        since++;
        if (since == 3) begin stop = 1'b1; stopped = 1; end
      end
      if (bstart && start_cyc.size() >= 1 && !bstarted) begin
        start = 1'b1; bstarted = 1;
        mode = 2'd0; seed = 8'h77; pkt_len = 16'd9; pkt_cnt = 16'd5;
      end
    end
    start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " run_done pulses"}, rd_cnt, 1);
    check({tag, " busy during run_done"}, rd_busy_bad, 0);
    check({tag, " busy after run"}, busy, 0);
    check({tag, " pkts_sent"}, pkts_sent, exp_pkts);
    check({tag, " tx_data idle"}, tif.tx_data, 0);
    check({tag, " packets started"}, start_cyc.size(), exp_pkts);
    check({tag, " packets done"}, done_cyc.size(), exp_pkts);
    check({tag, " bytes received"}, rx_q.size(), exp_pkts * eff_len);
    ofs = 0;
    for (int p = 0; p < start_cyc.size(); p++) begin
      check($sformatf("%s byte_num pkt%0d", tag, p), len_obs[p], eff_len);
      nbad = 0; fb = -1;
      for (int i = 0; i < eff_len; i++) begin
        w = exp_word(m, sd, i);
        if (ofs + i >= rx_q.size() || rx_q[ofs + i] !== w) begin
          nbad++;
          if (fb < 0) fb = i;
        end
      end
      if (nbad != 0)
        $display("[TB] %s pkt%0d first diff at word %0d, want 0x%0h", tag, p, fb, exp_word(m, sd, fb));
      check($sformatf("%s payload errors pkt%0d", tag, p), nbad, 0);
      ofs += eff_len;
    end
    for (int p = 1; p < start_cyc.size() && p <= done_cyc.size(); p++)
      check($sformatf("%s done->start gap pkt%0d", tag, p), start_cyc[p] - done_cyc[p-1], gp + 1);
    if (exp_last >= 0) begin
      lb = 8'hxx;
      if (rx_q.size() >= eff_len) lb = rx_q[eff_len-1];
      check({tag, " last word pkt0"}, lb, exp_last);
    end
    $display("[TB] %s: mode=%0d seed=0x%0h len=%0d cnt=%0d gap=%0d -> %0d pkts, pkts_sent=%0d",
             tag, m, sd, ln, cn, gp, start_cyc.size(), pkts_sent);
  endtask

  typedef struct {
    int m; int sd; int ln; int cn; int gp;
    int stop_at; bit bstart; int exp_pkts; int exp_last;
  } vec_t;

  vec_t vt [7];

  initial begin
    int t;
    vt[0] = '{0, 'h00, 10, 1, 0,   0, 1'b0, 1, 'h99};  // INCR 00 11 .. 99
    vt[1] = '{1, 'hA5, 30, 3, 100, 0, 1'b0, 3, 'hA5};  // CONST, 101-cycle spacing
    vt[2] = '{2, 'h01, 4,  2, 3,   0, 1'b0, 2, 'h00};  // PRBS 01 00 00 00 twice
    vt[3] = '{0, 'h10, 12, 0, 2,   3, 1'b0, 3, -1};    // continuous, stop in pkt 3
    vt[4] = '{1, 'h5A, 0,  2, 1,   0, 1'b1, 2, 'h5A};  // len 0 clamp, start while busy
    vt[5] = '{3, 'hC3, 5,  2, 0,  -1, 1'b0, 2, 'hC3};  // reserved mode, start+stop in IDLE
    vt[6] = '{2, 'h00, 6,  1, 0,   0, 1'b0, 1, 'h40};  // PRBS zero seed

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; seed = '0;
    pkt_len = '0; pkt_cnt = '0; gap_cyc = '0;
    repeat (3) @(negedge clk);
    check("reset tx_start_en", tif.tx_start_en, 0);
    check("reset tx_byte_num", tif.tx_byte_num, 0);
    check("reset tx_data", tif.tx_data, 0);
    check("reset busy", busy, 0);
    check("reset pkts_sent", pkts_sent, 0);
    check("reset run_done", run_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_run($sformatf("vec%0d", i), vt[i].m, vt[i].sd, vt[i].ln, vt[i].cn, vt[i].gp,
             vt[i].stop_at, vt[i].bstart, vt[i].exp_pkts, vt[i].exp_last);

    // Reset in the middle of a packet, then a clean frame.
    @(negedge clk);
    start_cyc.delete();
    mode = 2'd0; seed = 8'h20; pkt_len = 16'd40; pkt_cnt = 16'd1; gap_cyc = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (start_cyc.size() == 0 && t < 200) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check("midrst busy before reset", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst tx_start_en", tif.tx_start_en, 0);
    check("midrst tx_byte_num", tif.tx_byte_num, 0);
    check("midrst tx_data", tif.tx_data, 0);
    check("midrst busy", busy, 0);
    check("midrst pkts_sent", pkts_sent, 0);
    check("midrst run_done", run_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run("after_rst", 0, 'h20, 8, 1, 0, 0, 1'b0, 1, 'h97);

    for (int r = 0; r < 15; r++) begin
      int m, sd, ln, cn, gp;
      m  = $urandom_range(0, 3);
      sd = $urandom_range(0, 255);
      ln = $urandom_range(0, 20);
      cn = $urandom_range(1, 3);
      gp = $urandom_range(0, 6);
      do_run($sformatf("rand%0d", r), m, sd, ln, cn, gp, 0, 1'b0, cn, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
